rect_fill_engine: RTL and testbench
===================================

// Module: rect_fill_engine
// PURPOSE
//  Hardware rectangle-fill blitter: the write side of the pixel framebuffer that the VGA scan-out reads.
//  CPU issues one start pulse with origin, size and colour.
//  The engine walks the clipped rectangle in raster order, driving one framebuffer write per clock.
//  Sits between CPU and Memory write port (XWrite/YWrite/writeValueMemory); frees CPU from per-pixel stores.
// PARAMETERS
//  ImageWidth   320  canvas width in pixels; X range 0..ImageWidth-1
//  ImageHeight  240  canvas height in pixels; Y range 0..ImageHeight-1
//  ColorBits    3    colour code width
// PORTS
//  clk               in   1          system clock, all logic on rising edge
//  reset             in   1          synchronous, active-high reset
//  start             in   1          command strobe; sampled only in IDLE
//  x0                in   9          rectangle left column
//  y0                in   8          rectangle top row
//  w                 in   9          rectangle width in pixels
//  h                 in   8          rectangle height in pixels
//  color             in   ColorBits  fill colour
//  busy              out  1          high from cycle after accepted start until DONE exits
//  done              out  1          one-cycle completion pulse
//  XWrite            out  9          framebuffer write column
//  YWrite            out  8          framebuffer write row
//  writeValueMemory  out  ColorBits  framebuffer write data
//  writeEnable       out  1          write strobe; XWrite/YWrite/data valid only when high
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - state=IDLE; busy, done, writeEnable = 0; XWrite, YWrite, writeValueMemory = 0.
//   - Takes priority in any state; a fill in progress is abandoned with no further writes and no done.
//  States:
//   IDLE:
//    - start=1 -> register x0,y0,w,h,color; go CLIP.
//    - start=0 -> stay.
//   CLIP (1 cycle, no write):
//    - xe = min(x0+w, ImageWidth)-1, 10-bit math; ye = min(y0+h, ImageHeight)-1, 9-bit math.
//    - w==0, h==0, x0>=ImageWidth or y0>=ImageHeight -> go DONE with zero writes.
//    - Otherwise cx=x0, cy=y0; go FILL.
//   FILL (one pixel per cycle):
//    - writeEnable=1, XWrite=cx, YWrite=cy, writeValueMemory=latched color.
//    - Next pixel: cx==xe -> cx=x0 latched, cy++; else cx++.
//    - Last pixel is cx==xe && cy==ye -> go DONE next cycle.
//   DONE (1 cycle):
//    - done=1, writeEnable=0; go IDLE.
//  Timing:
//   - Accepted start at edge N -> busy=1 from N+1.
//   - First write (if any) is presented in cycle N+2.
//   - Total cycles from start to done = 2 + Wc*Hc, where Wc, Hc are the clipped sizes.
//  Outputs:
//   - busy=1 in CLIP, FILL and DONE.
//   - start while busy is ignored; inputs are not re-sampled mid-fill.
//   - Command inputs are sampled only on the accepting edge; later changes do not affect the fill.
//   - Outside FILL, writeEnable=0; XWrite/YWrite hold their last value (don't-care to the memory).
//   - Registered outputs only; no combinational path from inputs to outputs.
//  Wrap and overflow:
//   - No wrap: pixels at x>=ImageWidth or y>=ImageHeight are never written.
//   - Sums are carried in widened math so that x0=511,w=511 cannot alias into range.
//  Simultaneous events:
//   - start in the same cycle as the DONE->IDLE transition is ignored.
//   - A start asserted in the IDLE cycle after DONE is accepted: back-to-back throughput of 1 idle cycle.
// TESTING
//  1. x0=10,y0=20,w=3,h=2,color=5
//     -> writes (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), all data 5.
//     -> done 8 cycles after start; exactly 6 writeEnable cycles.
//  2. x0=318,y0=238,w=5,h=5 -> clipped to (318..319, 238..239): 4 writes; done at start+6.
//  3. w=0 (or h=0, or x0=320, or y0=240) -> zero writes; done pulse 2 cycles after start; busy drops after.
//  4. Start a 100x100 fill; assert reset after 37 writes
//     -> writeEnable=0 the next cycle, busy=0, no done pulse.
//     -> A new start after reset proceeds normally.
//  5. Pulse start (color=2) repeatedly during a 4x4 fill
//     -> exactly 16 writes with colour 2; second command ignored.
//     -> Start in first IDLE cycle after done launches new fill.
//  6. x0=511,y0=255,w=511,h=255 -> no writes (out of canvas), done at start+2; no alias writes near origin.

Source files
------------

// File: rtl/rect_fill_engine_if.sv
// Command and framebuffer-write bundle of the rectangle-fill blitter.
// The CPU side is master; the engine is slave.
interface rect_fill_engine_if #(
   parameter int unsigned ColorBits = 3
);
   logic                 start;
   logic [8:0]           x0;
   logic [7:0]           y0;
   logic [8:0]           w;
   logic [7:0]           h;
   logic [ColorBits-1:0] color;
   logic                 busy;
   logic                 done;
   logic [8:0]           XWrite;
   logic [7:0]           YWrite;
   logic [ColorBits-1:0] writeValueMemory;
   logic                 writeEnable;

   modport master (
      output start, x0, y0, w, h, color,
      input  busy, done, XWrite, YWrite, writeValueMemory, writeEnable
   );

   modport slave (
      input  start, x0, y0, w, h, color,
      output busy, done, XWrite, YWrite, writeValueMemory, writeEnable
   );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle-fill blitter: walks a canvas-clipped rectangle in raster order,
// issuing one framebuffer write per clock.
module rect_fill_engine #(
   parameter int unsigned ImageWidth  = 320,
   parameter int unsigned ImageHeight = 240,
   parameter int unsigned ColorBits   = 3
) (
   input  logic               clk,
   input  logic               reset,
   rect_fill_engine_if.slave  bus
);
   localparam logic [9:0] XLIM = 10'(ImageWidth);
   localparam logic [8:0] YLIM = 9'(ImageHeight);
   localparam logic [8:0] XMAX = 9'(ImageWidth - 1);
   localparam logic [7:0] YMAX = 8'(ImageHeight - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [8:0]           x0_q, x0_d, w_q, w_d, xe_q, xe_d, cx_q, cx_d;
   logic [7:0]           y0_q, y0_d, h_q, h_d, ye_q, ye_d, cy_q, cy_d;
   logic [ColorBits-1:0] color_q, color_d;

   logic [9:0] xsum;
   logic [8:0] ysum;
   logic       empty;

   // Widened sums keep e.g. x0=511,w=511 from wrapping back onto the canvas.
   assign xsum  = {1'b0, x0_q} + {1'b0, w_q};
   assign ysum  = {1'b0, y0_q} + {1'b0, h_q};
   assign empty = (w_q == '0) || (h_q == '0) ||
                  ({1'b0, x0_q} >= XLIM) || ({1'b0, y0_q} >= YLIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         color_q <= color_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      color_d = color_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x0_d    = bus.x0;
               y0_d    = bus.y0;
               w_d     = bus.w;
               h_d     = bus.h;
               color_d = bus.color;
               state_d = S_CLIP;
            end
         end
         S_CLIP: begin
            xe_d = (xsum >= XLIM) ? XMAX : 9'(xsum - 10'd1);
            ye_d = (ysum >= YLIM) ? YMAX : 8'(ysum - 9'd1);
            if (empty) begin
               state_d = S_DONE;
            end else begin
               cx_d    = x0_q;
               cy_d    = y0_q;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (cx_q == xe_q) begin
               if (cy_q == ye_q) begin
                  state_d = S_DONE;
               end else begin
                  cx_d = x0_q;
                  cy_d = cy_q + 8'd1;
               end
            end else begin
               cx_d = cx_q + 9'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode registered state only; coordinates hold outside FILL.
   assign bus.busy             = (state_q != S_IDLE);
   assign bus.done             = (state_q == S_DONE);
   assign bus.writeEnable      = (state_q == S_FILL);
   assign bus.XWrite           = cx_q;
   assign bus.YWrite           = cy_q;
   assign bus.writeValueMemory = color_q;
endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: write lists, latency, clipping,
// reset abort and start-while-busy behaviour.
module tb_rect_fill_engine;
   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   rect_fill_engine_if #(.ColorBits(3)) bus ();

   rect_fill_engine #(
      .ImageWidth (320),
      .ImageHeight(240),
      .ColorBits  (3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } wr_t;

   wr_t wq[$];
   int  done_seen = 0;
   int  checks    = 0;
   int  errors    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.writeEnable === 1'b1)
         wq.push_back('{bus.XWrite, bus.YWrite, bus.writeValueMemory});
      if (bus.done === 1'b1)
         done_seen++;
   endtask

   task automatic set_cmd(input int x0, input int y0, input int w, input int h, input int c);
      bus.x0    = 9'(x0);
      bus.y0    = 8'(y0);
      bus.w     = 9'(w);
      bus.h     = 8'(h);
      bus.color = 3'(c);
   endtask

   // Expected raster list for inclusive corners (x0,y0)..(xe,ye).
   task automatic check_pixels(input string tag, input int x0, input int y0,
                               input int xe, input int ye, input int c);
      int idx;
      int n;
      wr_t e;
      n = (xe - x0 + 1) * (ye - y0 + 1);
      check({tag, " nwrites"}, wq.size(), n);
      idx = 0;
      for (int y = y0; y <= ye; y++) begin
         for (int x = x0; x <= xe; x++) begin
            if (idx < wq.size()) begin
               e = '{9'(x), 8'(y), 3'(c)};
               check({tag, " pixel"}, 32'(wq[idx]), 32'(e));
            end
            idx++;
         end
      end
   endtask

   task automatic run_fill(input string tag, input int x0, input int y0, input int w,
                           input int h, input int c, input int exp_cycles);
      int n;
      wq.delete();
      set_cmd(x0, y0, w, h, c);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 1;
      check({tag, " busy"}, 32'(bus.busy), 1);
      while (bus.done !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      check({tag, " cycles"}, n, exp_cycles);
      tick();
      check({tag, " done-pulse"}, 32'(bus.done), 0);
      check({tag, " busy-drop"}, 32'(bus.busy), 0);
   endtask

   initial begin
      int n;
      int d0;
      bus.start = 1'b0;
      set_cmd(0, 0, 0, 0, 0);
      tick();
      tick();
      check("rst busy", 32'(bus.busy), 0);
      check("rst done", 32'(bus.done), 0);
      check("rst we", 32'(bus.writeEnable), 0);
      check("rst x", 32'(bus.XWrite), 0);
      check("rst y", 32'(bus.YWrite), 0);
      check("rst data", 32'(bus.writeValueMemory), 0);
      reset = 1'b0;
      tick();

      run_fill("t1", 10, 20, 3, 2, 5, 8);
      check_pixels("t1", 10, 20, 12, 21, 5);

      run_fill("t2", 318, 238, 5, 5, 6, 6);
      check_pixels("t2", 318, 238, 319, 239, 6);

      run_fill("t3w0", 10, 10, 0, 4, 1, 2);
      check("t3w0 nwrites", wq.size(), 0);
      run_fill("t3h0", 10, 10, 4, 0, 1, 2);
      check("t3h0 nwrites", wq.size(), 0);
      run_fill("t3x", 320, 10, 4, 4, 1, 2);
      check("t3x nwrites", wq.size(), 0);
      run_fill("t3y", 10, 240, 4, 4, 1, 2);
      check("t3y nwrites", wq.size(), 0);

      run_fill("t6", 511, 255, 511, 255, 7, 2);
      check("t6 nwrites", wq.size(), 0);

      // Reset abort after 37 writes of a 100x100 fill.
      wq.delete();
      set_cmd(0, 0, 100, 100, 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 1;
      while (wq.size() < 37 && n < 200) begin
         tick();
         n++;
      end
      check("t4 writes-before-reset", wq.size(), 37);
      d0 = done_seen;
      reset = 1'b1;
      tick();
      check("t4 we", 32'(bus.writeEnable), 0);
      check("t4 busy", 32'(bus.busy), 0);
      reset = 1'b0;
      repeat (20) tick();
      check("t4 no-done", done_seen, d0);
      check("t4 no-more-writes", wq.size(), 37);
      run_fill("t4post", 10, 20, 3, 2, 5, 8);
      check_pixels("t4post", 10, 20, 12, 21, 5);

      // Start toggled with junk commands during a 4x4 fill must be ignored.
      wq.delete();
      set_cmd(5, 6, 4, 4, 2);
      bus.start = 1'b1;
      tick();
      n = 1;
      while (bus.done !== 1'b1 && n < 100) begin
         bus.start = n[0];
         set_cmd(100, 50, 1, 1, 7);
         tick();
         n++;
      end
      check("t5 cycles", n, 18);
      set_cmd(0, 0, 1, 1, 4);
      bus.start = 1'b1;
      check_pixels("t5", 5, 6, 8, 9, 2);
      wq.delete();
      tick();
      check("t5 idle busy", 32'(bus.busy), 0);
      check("t5 idle done", 32'(bus.done), 0);
      tick();
      bus.start = 1'b0;
      check("t5 relaunch busy", 32'(bus.busy), 1);
      n = 1;
      while (bus.done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("t5 relaunch cycles", n, 3);
      check_pixels("t5b", 0, 0, 0, 0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
